// File: rtl/const_table_pkg.sv
// Shared encodings, state type and helpers for the immediate-table loader.
package const_table_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd40;

  localparam logic [1:0] FMT_I12  = 2'd0;
  localparam logic [1:0] FMT_J20  = 2'd1;
  localparam logic [1:0] FMT_U32  = 2'd2;
  localparam logic [1:0] FMT_RSVD = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ADDR  = 2'd1;
  localparam logic [1:0] ERR_FMT   = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [1:0] {
    StClear,
    StLoad,
    StLocked
  } state_e;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [31:0] value;
  } entry_t;

  // True when addr is word aligned and falls inside [base, base + 4*n).
  function automatic logic addr_in_table(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned n);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(n) << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational record checker: maps an address to an entry index and classifies the record.
module imm_range_check
  import const_table_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic [31:0]                    wr_addr,
  input  logic [1:0]                     wr_fmt,
  input  logic [31:0]                    wr_data,
  output logic [$clog2(NUM_ENTRIES)-1:0] idx,
  output logic                           ok,
  output logic [1:0]                     err_code
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  logic range_ok;

  always_comb begin
    range_ok = 1'b0;
    case (wr_fmt)
      FMT_I12: range_ok = (wr_data[31:11] == '0) || (wr_data[31:11] == '1);
      FMT_J20: range_ok = !wr_data[0] && ((wr_data[31:20] == '0) || (wr_data[31:20] == '1));
      FMT_U32: range_ok = (wr_data[11:0] == '0);
      default: range_ok = 1'b0;
    endcase
  end

  // Address beats format beats range when several checks fail.
  always_comb begin
    err_code = ERR_NONE;
    if (!addr_in_table(wr_addr, BASE_ADDR, NUM_ENTRIES)) begin
      err_code = ERR_ADDR;
    end else if (wr_fmt == FMT_RSVD) begin
      err_code = ERR_FMT;
    end else if (!range_ok) begin
      err_code = ERR_RANGE;
    end
  end

  assign ok  = (err_code == ERR_NONE);
  assign idx = IdxW'((wr_addr - BASE_ADDR) >> 2);

endmodule

// File: rtl/const_table_writer.sv
// Loads, validates and locks the per-instruction immediate table; serves registered lookups.
module const_table_writer
  import const_table_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [31:0]                      wr_addr,
  input  logic [1:0]                       wr_fmt,
  input  logic [31:0]                      wr_data,
  input  logic                             load_done,
  input  logic [31:0]                      rd_addr,
  output logic                             rd_hit,
  output logic [1:0]                       rd_fmt,
  output logic [11:0]                      rd_imm12,
  output logic [19:0]                      rd_imm20,
  output logic [31:0]                      rd_imm32,
  output logic                             loaded,
  output logic                             wr_err,
  output logic [1:0]                       wr_err_code,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] wr_count
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = $clog2(NUM_ENTRIES + 1);

  state_e           state_q;
  logic [IdxW-1:0]  clr_idx_q;
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [CntW-1:0]  count_q;
  logic             wr_err_q;
  logic [1:0]       wr_err_code_q;
  entry_t           mem_q [NUM_ENTRIES];
  entry_t           rd_entry_q;
  logic             rd_hit_q;

  logic [IdxW-1:0]  wr_idx;
  logic             wr_ok;
  logic [1:0]       wr_code;
  logic [IdxW-1:0]  rd_idx;
  logic             rd_in_table;
  logic             wr_fire;
  logic             wr_accept;

  imm_range_check #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_check (
    .wr_addr (wr_addr),
    .wr_fmt  (wr_fmt),
    .wr_data (wr_data),
    .idx     (wr_idx),
    .ok      (wr_ok),
    .err_code(wr_code)
  );

  assign rd_idx      = IdxW'((rd_addr - BASE_ADDR) >> 2);
  assign rd_in_table = addr_in_table(rd_addr, BASE_ADDR, NUM_ENTRIES);
  assign wr_ready    = (state_q == StLoad);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_accept   = wr_fire && wr_ok;

  // Valid bits carry no reset of their own; the CLEAR sweep retires them one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClear;
      clr_idx_q     <= '0;
      count_q       <= '0;
      wr_err_q      <= 1'b0;
      wr_err_code_q <= ERR_NONE;
    end else begin
      wr_err_q      <= wr_fire && !wr_ok;
      wr_err_code_q <= wr_fire ? wr_code : ERR_NONE;
      if (wr_accept) begin
        valid_q[wr_idx] <= 1'b1;
        if (!valid_q[wr_idx]) count_q <= count_q + 1'b1;
      end
      case (state_q)
        StClear: begin
          valid_q[clr_idx_q] <= 1'b0;
          clr_idx_q          <= clr_idx_q + 1'b1;
          if (clr_idx_q == IdxW'(NUM_ENTRIES - 1)) state_q <= StLoad;
        end
        StLoad: begin
          if (load_done) state_q <= StLocked;
        end
        default: ;
      endcase
    end
  end

  // Single write port, single registered read port; a same-edge read sees the old entry.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_idx] <= {wr_fmt, wr_data};
    rd_entry_q <= mem_q[rd_idx];
  end

  // Valid bits are stale until the sweep finishes, so nothing hits while clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hit_q <= 1'b0;
    end else begin
      rd_hit_q <= rd_in_table && valid_q[rd_idx] && (state_q != StClear);
    end
  end

  always_comb begin
    rd_fmt   = '0;
    rd_imm12 = '0;
    rd_imm20 = '0;
    rd_imm32 = '0;
    if (rd_hit_q) begin
      rd_fmt = rd_entry_q.fmt;
      case (rd_entry_q.fmt)
        FMT_I12: rd_imm12 = rd_entry_q.value[11:0];
        FMT_J20: rd_imm20 = rd_entry_q.value[20:1];
        FMT_U32: rd_imm32 = rd_entry_q.value;
        default: ;
      endcase
    end
  end

  assign rd_hit      = rd_hit_q;
  assign loaded      = (state_q == StLocked);
  assign wr_err      = wr_err_q;
  assign wr_err_code = wr_err_code_q;
  assign wr_count    = count_q;

endmodule

// File: tb/tb_const_table_writer.sv
// Scoreboard bench for const_table_writer: lookups and write errors queued at drive time.
module tb_const_table_writer;
  import const_table_pkg::*;

  localparam int unsigned N    = 32;
  localparam logic [31:0] BASE = 32'd40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [1:0]  wr_fmt = '0;
  logic [31:0] wr_data = '0;
  logic        load_done = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_hit;
  logic [1:0]  rd_fmt;
  logic [11:0] rd_imm12;
  logic [19:0] rd_imm20;
  logic [31:0] rd_imm32;
  logic        loaded;
  logic        wr_err;
  logic [1:0]  wr_err_code;
  logic [5:0]  wr_count;

  logic [4:0]  ref_idx;
  logic        ref_ok;
  logic [1:0]  ref_code;

  always #5 clk = ~clk;

  const_table_writer #(
    .BASE_ADDR  (BASE),
    .NUM_ENTRIES(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_fmt     (wr_fmt),
    .wr_data    (wr_data),
    .load_done  (load_done),
    .rd_addr    (rd_addr),
    .rd_hit     (rd_hit),
    .rd_fmt     (rd_fmt),
    .rd_imm12   (rd_imm12),
    .rd_imm20   (rd_imm20),
    .rd_imm32   (rd_imm32),
    .loaded     (loaded),
    .wr_err     (wr_err),
    .wr_err_code(wr_err_code),
    .wr_count   (wr_count)
  );

  imm_range_check #(
    .BASE_ADDR  (BASE),
    .NUM_ENTRIES(N)
  ) u_ref (
    .wr_addr (wr_addr),
    .wr_fmt  (wr_fmt),
    .wr_data (wr_data),
    .idx     (ref_idx),
    .ok      (ref_ok),
    .err_code(ref_code)
  );

  typedef struct packed {
    logic        hit;
    logic [1:0]  fmt;
    logic [11:0] i12;
    logic [19:0] i20;
    logic [31:0] i32;
  } rd_t;

  rd_t        rd_exp_q [$];
  logic [2:0] err_exp_q [$];
  rd_t        e_rd;
  logic [2:0] e_err;

  int errors = 0;
  int checks = 0;

  logic rd_req = 1'b0, wr_req = 1'b0, rd_req_d = 1'b0, wr_req_d = 1'b0, mon_en = 1'b0;

  logic        m_valid [N];
  logic [1:0]  m_fmt [N];
  logic [31:0] m_val [N];
  int          m_count = 0;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic rd_t model_rd(input logic [31:0] a);
    rd_t r;
    int  i;
    r = '0;
    if (a[1:0] == 2'b00 && a >= BASE && a < BASE + 4 * N) begin
      i = int'((a - BASE) >> 2);
      if (m_valid[i]) begin
        r.hit = 1'b1;
        r.fmt = m_fmt[i];
        case (m_fmt[i])
          FMT_I12: r.i12 = m_val[i][11:0];
          FMT_J20: r.i20 = m_val[i][20:1];
          default: r.i32 = m_val[i];
        endcase
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    wr_valid  = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] a);
    rd_addr = a;
    rd_req  = 1'b1;
    rd_exp_q.push_back(model_rd(a));
  endtask

  task automatic wr_issue(input logic [31:0] a, input logic [1:0] f, input logic [31:0] d,
                          input logic [1:0] code);
    int i;
    check("wr_ready_load", 67'(wr_ready), 67'(1));
    wr_addr  = a;
    wr_fmt   = f;
    wr_data  = d;
    wr_valid = 1'b1;
    wr_req   = 1'b1;
    err_exp_q.push_back({code != ERR_NONE, code});
    if (code == ERR_NONE) begin
      i = int'((a - BASE) >> 2);
      if (!m_valid[i]) m_count++;
      m_valid[i] = 1'b1;
      m_fmt[i]   = f;
      m_val[i]   = d;
    end
    #1;
    check("chk_code", 67'(ref_code), 67'(code));
    check("chk_ok", 67'(ref_ok), 67'(code == ERR_NONE));
    if (code == ERR_NONE) check("chk_idx", 67'(ref_idx), 67'((a - BASE) >> 2));
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    repeat (hold) step();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_count = 0;
    check("rst_ready", 67'(wr_ready), 67'(0));
    check("rst_loaded", 67'(loaded), 67'(0));
    check("rst_count", 67'(wr_count), 67'(0));
    check("rst_err", 67'({wr_err, wr_err_code}), 67'(0));
    check("rst_rd", 67'({rd_hit, rd_fmt, rd_imm12, rd_imm20, rd_imm32}), 67'(0));
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Counts edges after the last reset edge until wr_ready rises, looking up entries meanwhile.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!wr_ready && n < 100) begin
      rd_issue(BASE + 32'(4 * (n % N)));
      step();
      n++;
    end
    check("ready_latency", 67'(n), 67'(N));
  endtask

  always @(posedge clk) begin
    rd_req_d <= rd_req;
    wr_req_d <= wr_req;
  end

  always @(negedge clk) begin
    if (rd_req_d) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_queue_underflow", 67'(1), 67'(0));
      end else begin
        e_rd = rd_exp_q.pop_front();
        check("lookup", 67'({rd_hit, rd_fmt, rd_imm12, rd_imm20, rd_imm32}), 67'(e_rd));
      end
    end
    if (wr_req_d) begin
      if (err_exp_q.size() == 0) begin
        check("err_queue_underflow", 67'(1), 67'(0));
      end else begin
        e_err = err_exp_q.pop_front();
        check("wr_err", 67'({wr_err, wr_err_code}), 67'(e_err));
      end
    end else if (mon_en) begin
      check("wr_err_idle", 67'({wr_err, wr_err_code}), 67'(0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);
    wait_ready();

    // Back-to-back accepted writes, including the last entry.
    wr_issue(32'd40, FMT_I12, 32'd25, ERR_NONE);          step();
    wr_issue(32'd92, FMT_J20, 32'd246, ERR_NONE);         step();
    wr_issue(32'd140, FMT_U32, 32'h000F_6000, ERR_NONE);  step();
    wr_issue(32'd164, FMT_J20, 32'hFFFF_FFFE, ERR_NONE);  step();
    check("count_after_writes", 67'(wr_count), 67'(m_count));
    rd_issue(32'd40);  step();
    rd_issue(32'd92);  step();
    rd_issue(32'd140); step();
    rd_issue(32'd164); step();
    check("imm12_40", 67'(rd_imm12), 67'(0));  // previous read was U32-less J20 entry
    rd_issue(32'd40);  step();
    check("imm12_direct", 67'(rd_imm12), 67'(25));

    // Rejected records.
    wr_issue(32'd42, FMT_I12, 32'd1, ERR_ADDR);           step();
    wr_issue(32'd172, FMT_I12, 32'd1, ERR_ADDR);          step();
    wr_issue(32'd36, FMT_I12, 32'd1, ERR_ADDR);           step();
    wr_issue(32'd60, FMT_RSVD, 32'd1, ERR_FMT);           step();
    wr_issue(32'd60, FMT_I12, 32'd2048, ERR_RANGE);       step();
    wr_issue(32'd64, FMT_J20, 32'd5, ERR_RANGE);          step();
    wr_issue(32'd68, FMT_U32, 32'h0000_1001, ERR_RANGE);  step();
    step();
    check("count_after_rejects", 67'(wr_count), 67'(4));
    rd_issue(32'd60);  step();
    rd_issue(32'd92);  step();
    rd_issue(32'd42);  step();

    // Rewrite and same-edge read/write.
    wr_issue(32'd40, FMT_I12, 32'd8, ERR_NONE);           step();
    wr_issue(32'd44, FMT_I12, 32'd5, ERR_NONE);           step();
    rd_issue(32'd40);  step();
    check("count_rewrite", 67'(wr_count), 67'(5));
    rd_issue(32'd44);
    wr_issue(32'd44, FMT_I12, 32'hFFFF_FFF9, ERR_NONE);   step();
    rd_issue(32'd44);  step();
    step();
    check("count_same_edge", 67'(wr_count), 67'(m_count));

    // Reset mid-LOAD, then mid-CLEAR.
    do_reset(1);
    rd_issue(32'd40);  step();
    for (int k = 0; k < 10; k++) begin
      rd_issue(BASE + 32'(4 * k));
      step();
    end
    do_reset(2);
    wait_ready();
    rd_issue(32'd40);  step();
    check("count_post_reset", 67'(wr_count), 67'(0));

    // load_done together with a record.
    wr_issue(32'd40, FMT_U32, 32'h1234_5000, ERR_NONE);   step();
    wr_issue(32'd48, FMT_I12, 32'd8, ERR_NONE);
    load_done = 1'b1;
    step();
    check("loaded", 67'(loaded), 67'(1));
    check("locked_ready", 67'(wr_ready), 67'(0));
    for (int k = 0; k < 3; k++) begin
      wr_addr  = 32'd52;
      wr_fmt   = FMT_I12;
      wr_data  = 32'd3;
      wr_valid = 1'b1;
      #1;
      check("locked_no_ready", 67'(wr_ready), 67'(0));
      step();
    end
    rd_issue(32'd48);  step();
    rd_issue(32'd52);  step();
    rd_issue(32'd40);  step();
    step();
    check("count_locked", 67'(wr_count), 67'(2));
    check("still_loaded", 67'(loaded), 67'(1));

    step();
    check("rd_queue_empty", 67'(rd_exp_q.size()), 67'(0));
    check("err_queue_empty", 67'(err_exp_q.size()), 67'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/const_table_writer.md
# const_table_writer

Loader and storage for the per-instruction immediate table consumed by the datapath. It accepts a handshaked stream of (instruction address, format, value) records, checks each one, and writes accepted records into an entry array. After software signals completion it locks the table, and from then on it serves registered immediate lookups by instruction address. It is the write-side counterpart of the core's address-indexed immediate lookup and sits between the boot/test loader and the decode stage.

## Interface
- BASE_ADDR, 40: instruction address of entry 0.
- NUM_ENTRIES, 32: number of entries. Entry i serves address BASE_ADDR+4*i.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write record present.
- wr_ready  out  1  block can accept a record this cycle.
- wr_addr  in  32  instruction address of the record.
- wr_fmt  in  2  record format: 0 = I12, 1 = J20, 2 = U32, 3 = reserved.
- wr_data  in  32  immediate value, sign-extended to 32 bits.
- load_done  in  1  one-cycle strobe that ends loading.
- rd_addr  in  32  lookup instruction address.
- rd_hit  out  1  lookup matched a valid entry.
- rd_fmt  out  2  format of the matched entry.
- rd_imm12  out  12  I12 immediate.
- rd_imm20  out  20  J20 immediate, bits [20:1].
- rd_imm32  out  32  U32 immediate.
- loaded  out  1  table is locked.
- wr_err  out  1  one-cycle pulse when a record is rejected.
- wr_err_code  out  2  rejection reason: 1 = address, 2 = format, 3 = range.
- wr_count  out  $clog2(NUM_ENTRIES+1)  number of valid entries.

## Operation
- FSM states: CLEAR → LOAD → LOCKED. Reset forces CLEAR from any state, including mid-load or mid-clear.
- CLEAR
  - Index counter starts at 0.
  - One entry valid bit is cleared per cycle, over NUM_ENTRIES cycles.
  - On the last index the FSM moves to LOAD.
  - wr_ready=0. load_done is ignored.
- LOAD
  - wr_ready=1. A handshake is wr_valid & wr_ready.
  - Checks, in priority order:
    - Address: the address must be 4-byte aligned and satisfy BASE_ADDR ≤ addr < BASE_ADDR+4*NUM_ENTRIES; else code 1.
    - Format: wr_fmt=3 gives code 2.
    - Range (code 3 on failure):
      - I12: wr_data[31:11] must be all equal.
      - J20: wr_data[0]=0 and wr_data[31:20] must be all equal.
      - U32: wr_data[11:0]=0.
  - Accepted record: the entry stores value, fmt, and valid=1.
  - Rejected record: the handshake still completes, the entry is unchanged, and wr_err pulses with wr_err_code.
  - wr_count increments only when a previously invalid entry becomes valid. Rewriting a valid entry does not change it.
- LOCKED
  - Entered on load_done while in LOAD.
  - wr_ready=0 and loaded=1.
  - Stays in LOCKED until reset.
- Lookup
  - Active in every state.
  - rd_hit=1 only if rd_addr maps to an entry, the address is aligned, and the entry is valid.
  - On a hit, the output field matching the entry format carries the value: rd_imm12=value[11:0], rd_imm20=value[20:1], or rd_imm32=value. The other two fields are 0.
  - On a miss, all immediate outputs, rd_fmt and rd_hit are 0.

## Timing
- Reset values: wr_ready=0, loaded=0, wr_err=0, wr_err_code=0, wr_count=0, rd_hit=0, rd_fmt=0, all rd_imm*=0. FSM=CLEAR, index=0.
- Entry storage has no reset; only the valid bits are cleared, through the CLEAR sweep.
- Reset is sampled high at edge E. wr_ready first rises after edge E+NUM_ENTRIES.
- Lookup latency is 1 cycle: rd_addr sampled at edge N gives outputs after edge N.
- Write-then-read: a record written at edge N is visible to an rd_addr sampled at N+1. If the same address is read and written at the same edge N, the read returns the pre-write contents.
- wr_err and wr_err_code are registered and valid the cycle after the handshake. wr_err_code returns to 0 with wr_err.
- load_done together with a handshake at the same edge: the record is processed normally, then the FSM enters LOCKED. loaded and wr_ready=0 appear after that edge.
- Back-to-back handshakes every cycle are supported in LOAD.

## Structure
- Package const_table_pkg holds:
  - the fmt encodings (FMT_I12, FMT_J20, FMT_U32, FMT_RSVD);
  - the error codes (ERR_NONE, ERR_ADDR, ERR_FMT, ERR_RANGE);
  - the FSM state type;
  - the default BASE_ADDR.
- One sub-module, imm_range_check: combinational. Inputs are wr_addr, wr_fmt and wr_data; outputs are the entry index, ok, and the error code. It is reused by the bench scoreboard.
- The entry array is written in a RAM-inferable style: one write port and one registered read port.

## Test plan
- Reset, then count edges → wr_ready rises exactly 32 cycles after reset release; every lookup before that gives rd_hit=0.
- Write I12 addr=40 data=25, J20 addr=92 data=246, U32 addr=140 data=0x000F6000 → reads of 40, 92 and 140 give:
  - rd_imm12=25;
  - rd_imm20=123;
  - rd_imm32=0x000F6000;
  - wr_count=3.
- Rejected writes → wr_err pulses each time; wr_count and the table are unchanged:
  - addr=42 gives code 1;
  - addr=172 gives code 1;
  - fmt=3 gives code 2;
  - I12 data=2048 gives code 3;
  - J20 data=5 gives code 3;
  - U32 data=0x1001 gives code 3.
- Rewrite addr=40 with 8, then read 40 → rd_imm12=8 and wr_count is unchanged. A same-edge read/write of addr 44 returns the old contents, and the next read returns the new contents.
- load_done together with a valid write of addr=48 data=8 → the record is stored, loaded=1 and wr_ready=0 next cycle, and further wr_valid is never accepted.
- Reset asserted mid-LOAD and mid-CLEAR → loaded=0, wr_count=0, rd_hit=0 for address 40, and wr_ready returns after 32 cycles.
